uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame state encoding and the default bit period.
package uart_pkg;

    // 50 MHz system clock at 115200 baud
    localparam int unsigned DefaultClksPerBit = 434;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO with a registered occupancy level; DEPTH must be a power of two.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned LW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          empty,
    output logic          full,
    output logic [LW-1:0] level
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8-bit UART transmitter, LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [7:0]                   s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         txd,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          load, pop, full, empty, baud_end;
    logic [7:0]    rd_data;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (s_valid),
        .wr_data(s_data),
        .rd_en  (pop),
        .rd_data(rd_data),
        .empty  (empty),
        .full   (full),
        .level  (fifo_level)
    );

    assign s_ready  = !full;
    assign txd      = txd_q;
    assign busy     = (state_q != StIdle) || !empty;
    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        load    = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: load = !empty;
            StStart: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                    txd_d   = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            StData: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        txd_d   = parity_q;
`else
                        state_d = StStop;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
`endif
            StStop: begin
                baud_d = baud_q + BW'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = StIdle;
                    load    = !empty;
                end
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        // Pop straight into the shifter; start bit appears on the next cycle
        if (load) begin
            pop     = 1'b1;
            shift_d = rd_data;
            state_d = StStart;
            baud_d  = '0;
            txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^rd_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes queue expected line waveforms; a negedge monitor
// captures each frame from txd and compares it, and tracks FIFO level/ready/busy per cycle.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, txd, busy;
    logic [2:0] fifo_level;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .txd       (txd),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          start_cyc[$];
    int          pushes = 0;
    int          starts = 0;
    int          frames = 0;
    bit          in_frame = 0;
    int          cnt = 0;
    logic [63:0] act_line = '0;
    bit          rst_pending = 1;
    bit          took = 0;
    int          took_cyc = 0;
    bit          saw_full = 0;

    function automatic void chk(input bit ok, input string msg);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s", msg);
        end
    endfunction

    // Line waveform of one frame, one entry per clock: start, 8 data LSB first, [parity], stop
    function automatic logic [63:0] frame_wave(input logic [7:0] b);
        logic [63:0] w;
        int n;
        w = '0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            n = i / CPB;
            if (n == 0)                          w[i] = 1'b0;
            else if (n <= 8)                     w[i] = b[n-1];
            else if (n == 9 && FRAME_BITS == 11) w[i] = ^b;
            else                                 w[i] = 1'b1;
        end
        return w;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int          lvl;
        logic [31:0] lv;
        logic [7:0]  b;
        logic [63:0] want;
        if (rst_pending) begin
            pushes = 0;
            starts = 0;
            in_frame = 0;
            cnt = 0;
            exp_q.delete();
            chk(txd === 1'b1 && busy === 1'b0 && fifo_level === 3'd0 && s_ready === 1'b1,
                $sformatf("reset_state txd=%b busy=%b level=%0d ready=%b, want 1 0 0 1",
                          txd, busy, fifo_level, s_ready));
        end else begin
            if (!in_frame && txd !== 1'b1) begin
                in_frame = 1;
                cnt = 0;
                act_line = '0;
                starts++;
                start_cyc.push_back(cyc);
            end
            if (in_frame) act_line[cnt] = txd;
            lvl = pushes - starts;
            lv = {29'd0, fifo_level};
            chk(lv === 32'(lvl), $sformatf("fifo_level got=%0d want=%0d @%0d", fifo_level, lvl, cyc));
            chk(s_ready === (lvl != DEPTH),
                $sformatf("s_ready got=%b want=%b @%0d", s_ready, lvl != DEPTH, cyc));
            chk(busy === (in_frame || lvl != 0),
                $sformatf("busy got=%b want=%b @%0d", busy, in_frame || lvl != 0, cyc));
            if (s_ready === 1'b0) saw_full = 1;
            if (in_frame) begin
                cnt++;
                if (cnt == FRAME_CYC) begin
                    in_frame = 0;
                    frames++;
                    chk(exp_q.size() != 0, $sformatf("frame_unexpected line=%h want none", act_line));
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        want = frame_wave(b);
                        chk(act_line === want, $sformatf("frame byte=%h got=%h want=%h",
                                                         b, act_line, want));
                    end
                end
            end
        end
        rst_pending = !reset_n;
        took = reset_n && s_valid && s_ready;
        if (took) begin
            exp_q.push_back(s_data);
            pushes++;
            took_cyc = cyc;
        end
    end

    task automatic send(input logic [7:0] b);
        bit got;
        got = 0;
        s_data = b;
        s_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (took) begin
                got = 1;
                break;
            end
        end
        #1;
        chk(got, $sformatf("send_accept byte=%h accepted=%b want 1", b, got));
        s_valid = 1'b0;
        s_data = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy && !in_frame && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        chk(ok, $sformatf("%s idle_reached=%b want 1", tag, ok));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, t, f0;
        bit ok;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single frame, first start cycle one cycle after the pop
        n0 = start_cyc.size();
        send(8'hA5);
        t = took_cyc;
        wait_idle("single_a5");
        chk(start_cyc.size() == n0 + 1 && start_cyc[n0] == t + 2,
            $sformatf("start_latency got=%0d want=%0d",
                      start_cyc.size() > n0 ? start_cyc[n0] - t : -1, 2));

        // Back-to-back frames with no idle gap
        n0 = start_cyc.size();
        send(8'h00);
        send(8'hFF);
        wait_idle("b2b");
        chk(start_cyc.size() == n0 + 2 && start_cyc[n0+1] - start_cyc[n0] == FRAME_CYC,
            $sformatf("b2b_spacing got=%0d want=%0d",
                      start_cyc.size() >= n0 + 2 ? start_cyc[n0+1] - start_cyc[n0] : -1,
                      FRAME_CYC));

        // Hold s_valid through six bytes so the FIFO fills
        saw_full = 0;
        for (int i = 0; i < 6; i++) send(8'($urandom));
        wait_idle("fill");
        chk(saw_full, $sformatf("fifo_full_seen got=%b want 1", saw_full));

        // Reset in the middle of data bit 3
        send(8'h3C);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (in_frame && cnt >= 16) begin
                ok = 1;
                break;
            end
        end
        #1;
        chk(ok, $sformatf("reach_bit3 got=%b want 1", ok));
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        f0 = frames;
        repeat (100) @(posedge clk);
        #1;
        chk(frames == f0 && txd === 1'b1,
            $sformatf("post_abort frames=%0d txd=%b want %0d 1", frames, txd, f0));

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        wait_idle("parity_07");
        send(8'h03);
        wait_idle("parity_03");
`endif

        // Random bytes with random gaps; s_data churns while s_valid is low
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 60)) begin
                @(posedge clk);
                #1 s_data = 8'($urandom);
            end
        end
        wait_idle("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
